// File: rtl/fx3_read_engine_if.sv
// FX3 GPIF-II slave-FIFO read pins plus the downstream sink strobe/backpressure,
// bundled so the engine and its surroundings share one port.
interface fx3_read_engine_if;
    logic        fx3_th1Ready;
    logic [15:0] fx3_databus_in;
    logic        fx3_nRead;
    logic        fx3_nOE;
    logic        fx3_address;
    logic        sink_almostFull;
    logic [15:0] out_data;
    logic        out_valid;

    modport master (
        input  fx3_th1Ready, fx3_databus_in, sink_almostFull,
        output fx3_nRead, fx3_nOE, fx3_address, out_data, out_valid
    );

    modport slave (
        output fx3_th1Ready, fx3_databus_in, sink_almostFull,
        input  fx3_nRead, fx3_nOE, fx3_address, out_data, out_valid
    );
endinterface

// File: rtl/fx3_read_engine.sv
// FX3 thread-1 burst reader: fixed-length read bursts, latency-matched capture pipe.
// Optional FX3_READ_SEQCHECK_EN adds a sticky test-pattern sequence checker (seqError).
module fx3_read_engine #(
    parameter int BURST_LEN    = 256,
    parameter int READ_LATENCY = 2,
    parameter int TURNAROUND   = 2
) (
    input  logic fx3_clock,
    input  logic fx3_nReset,
    input  logic enable,
    output logic busy,
`ifdef FX3_READ_SEQCHECK_EN
    output logic seqError,
`endif
    fx3_read_engine_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] PAUSE = 3'd4;
    localparam logic [2:0] TURN  = 3'd5;

    localparam logic [15:0] BURST_END  = 16'(BURST_LEN);
    localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);
    localparam logic [7:0]  DRAIN_LAST = 8'(READ_LATENCY - 1);
    localparam logic [7:0]  TURN_LAST  = 8'(TURNAROUND - 1);

    logic [2:0]              state;
    logic [15:0]             issue_cnt;
    logic [7:0]              wait_cnt;
    logic [READ_LATENCY:1]   vld_pipe;

    assign busy = (state != IDLE);

    // Bus strobes are registered alongside the state so each state's pin levels
    // hold for the whole time the state is occupied.
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            state           <= IDLE;
            issue_cnt       <= '0;
            wait_cnt        <= '0;
            bus.fx3_nRead   <= 1'b1;
            bus.fx3_nOE     <= 1'b1;
            bus.fx3_address <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !bus.fx3_th1Ready && !bus.sink_almostFull) begin
                        state           <= SETUP;
                        bus.fx3_nOE     <= 1'b0;
                        bus.fx3_address <= 1'b1;
                    end
                end
                SETUP: begin
                    state         <= READ;
                    bus.fx3_nRead <= 1'b0;
                end
                READ: begin
                    issue_cnt <= issue_cnt + 16'd1;
                    // Burst end and backpressure share the same exit; DRAIN tells them apart.
                    if (issue_cnt == BURST_LAST || bus.sink_almostFull) begin
                        state         <= DRAIN;
                        bus.fx3_nRead <= 1'b1;
                        wait_cnt      <= '0;
                    end
                end
                DRAIN: begin
                    if (wait_cnt == DRAIN_LAST) begin
                        wait_cnt <= '0;
                        if (issue_cnt == BURST_END) begin
                            state           <= TURN;
                            bus.fx3_nOE     <= 1'b1;
                            bus.fx3_address <= 1'b0;
                        end else begin
                            state <= PAUSE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                PAUSE: begin
                    if (!bus.sink_almostFull) begin
                        state         <= READ;
                        bus.fx3_nRead <= 1'b0;
                    end
                end
                TURN: begin
                    if (wait_cnt == TURN_LAST) begin
                        state     <= IDLE;
                        issue_cnt <= '0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Each issued read walks the pipe; the tail marks the cycle its data is on the bus.
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            vld_pipe      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            vld_pipe[1] <= ~bus.fx3_nRead;
            for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            bus.out_valid <= vld_pipe[READ_LATENCY];
            if (vld_pipe[READ_LATENCY]) bus.out_data <= bus.fx3_databus_in;
        end
    end

`ifdef FX3_READ_SEQCHECK_EN
    logic [15:0] expected;
    logic        seq_started;

    // Expected always resyncs to word+1, which equals expected+1 on a match.
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            seqError    <= 1'b0;
            expected    <= '0;
            seq_started <= 1'b0;
        end else if (vld_pipe[READ_LATENCY]) begin
            seq_started <= 1'b1;
            expected    <= bus.fx3_databus_in + 16'd1;
            if (seq_started && bus.fx3_databus_in != expected) seqError <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fx3_read_engine.sv
// Bench for fx3_read_engine: FX3 bus model feeds a scoreboard queue, sink strobes pop it.
module tb_fx3_read_engine;
    localparam int BL  = 8;
    localparam int LAT = 2;
    localparam int TA  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic busy;
`ifdef FX3_READ_SEQCHECK_EN
    logic seq_err;
`endif

    fx3_read_engine_if bus_if();

    fx3_read_engine #(.BURST_LEN(BL), .READ_LATENCY(LAT), .TURNAROUND(TA)) dut (
        .fx3_clock (clk),
        .fx3_nReset(rst_n),
        .enable    (enable),
        .busy      (busy),
`ifdef FX3_READ_SEQCHECK_EN
        .seqError  (seq_err),
`endif
        .bus       (bus_if)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] dl[0:LAT];
    logic [15:0] next_word;
    logic        corrupt = 1'b0;
    logic        prev_nrd = 1'b1;
    int nrd_cnt, nrd_runs, strobe_cnt, fall_cyc, first_strobe_cyc, first_run, turn_cnt;
    logic [15:0] last_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_counters();
        nrd_cnt = 0; nrd_runs = 0; strobe_cnt = 0; turn_cnt = 0;
        fall_cyc = -1; first_strobe_cyc = -1; first_run = -1;
    endtask

    // One clock: FX3 model answers reads LAT cycles later, then the sink side is scored.
    task automatic cycle();
        logic [15:0] w;
        @(negedge clk);
        cyc++;
        for (int i = LAT; i > 0; i--) dl[i] = dl[i-1];
        if (!bus_if.fx3_nRead) begin
            w = next_word + ((corrupt && next_word >= 16'h0104) ? 16'd1 : 16'd0);
            dl[0] = w;
            exp_q.push_back(w);
            next_word++;
        end else begin
            dl[0] = 16'hDEAD;
        end
        bus_if.fx3_databus_in = dl[LAT];

        if (!bus_if.fx3_nRead) nrd_cnt++;
        if (!bus_if.fx3_nRead && prev_nrd) begin
            nrd_runs++;
            if (fall_cyc < 0) fall_cyc = cyc;
        end
        if (bus_if.fx3_nRead && !prev_nrd && first_run < 0) first_run = nrd_cnt;
        prev_nrd = bus_if.fx3_nRead;

        if (bus_if.out_valid) begin
            strobe_cnt++;
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            chk("sb_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("data", bus_if.out_data, exp_q.pop_front());
            last_word = bus_if.out_data;
`ifdef FX3_READ_SEQCHECK_EN
            if (corrupt && bus_if.out_data == 16'h0103) chk("seq_before", seq_err, 0);
            if (corrupt && bus_if.out_data == 16'h0105) chk("seq_raised", seq_err, 1);
`endif
        end
    endtask

    // Run one burst; optional backpressure pulse and enable drop at given read counts.
    task automatic run_burst(input int af_at, input int af_len, input int en_drop_at);
        int rc, af_left;
        bit started, af_done;
        reset_counters();
        rc = 0; af_left = 0; started = 0; af_done = 0;
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (busy) started = 1;
            if (busy && bus_if.fx3_nOE) turn_cnt++;
            if (!bus_if.fx3_nRead) rc++;
            if ((en_drop_at == 0) ? busy : (rc >= en_drop_at)) enable = 1'b0;
            if (af_left > 0) begin
                af_left--;
                if (af_left == 0) bus_if.sink_almostFull = 1'b0;
            end
            if (af_at != 0 && !af_done && rc == af_at && !bus_if.fx3_nRead) begin
                bus_if.sink_almostFull = 1'b1;
                af_left = af_len;
                af_done = 1;
            end
            if (started && !busy) break;
        end
        enable = 1'b0;
        chk("burst_done", busy, 0);
    endtask

    initial begin
        int rc, saved;
        for (int i = 0; i <= LAT; i++) dl[i] = 16'hDEAD;
        bus_if.fx3_th1Ready = 1'b1;
        bus_if.sink_almostFull = 1'b0;
        bus_if.fx3_databus_in = 16'hDEAD;
        next_word = 16'h0100;
        reset_counters();

        // Reset state
        repeat (3) cycle();
        chk("rst_nRead", bus_if.fx3_nRead, 1);
        chk("rst_nOE", bus_if.fx3_nOE, 1);
        chk("rst_addr", bus_if.fx3_address, 0);
        chk("rst_valid", bus_if.out_valid, 0);
        chk("rst_data", bus_if.out_data, 0);
        chk("rst_busy", busy, 0);
`ifdef FX3_READ_SEQCHECK_EN
        chk("rst_seq", seq_err, 0);
`endif
        rst_n = 1'b1;
        cycle();

        // 1: plain burst
        bus_if.fx3_th1Ready = 1'b0;
        next_word = 16'h0100;
        run_burst(0, 0, 0);
        chk("t1_nrd", nrd_cnt, BL);
        chk("t1_runs", nrd_runs, 1);
        chk("t1_strobes", strobe_cnt, BL);
        chk("t1_latency", first_strobe_cyc - fall_cyc, LAT + 1);
        chk("t1_turn", turn_cnt, TA);
        chk("t1_last", last_word, 16'h0107);
        chk("t1_sb_empty", exp_q.size(), 0);
        saved = nrd_cnt;
        repeat (5) cycle();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_nrd", nrd_cnt, saved);

        // 2: backpressure on the 3rd read cycle for 5 cycles
        next_word = 16'h0100;
        run_burst(3, 5, 0);
        chk("t2_stall_reads", first_run <= 4, 1);
        chk("t2_runs", nrd_runs, 2);
        chk("t2_nrd", nrd_cnt, BL);
        chk("t2_strobes", strobe_cnt, BL);
        chk("t2_last", last_word, 16'h0107);
        chk("t2_sb_empty", exp_q.size(), 0);

        // 3: thread not ready keeps the engine idle
        reset_counters();
        bus_if.fx3_th1Ready = 1'b1;
        enable = 1'b1;
        next_word = 16'h0100;
        saved = 0;
        repeat (20) begin
            cycle();
            if (busy || !bus_if.fx3_nOE) saved++;
        end
        chk("t3_held", saved, 0);
        chk("t3_nrd", nrd_cnt, 0);
        bus_if.fx3_th1Ready = 1'b0;
        cycle();
        enable = 1'b0;
        chk("t3_setup_busy", busy, 1);
        chk("t3_setup_nOE", bus_if.fx3_nOE, 0);
        chk("t3_setup_addr", bus_if.fx3_address, 1);
        for (int i = 0; i < 60 && busy; i++) cycle();
        chk("t3_done", busy, 0);
        chk("t3_strobes", strobe_cnt, BL);

        // 4: reset on the 4th read cycle
        reset_counters();
        next_word = 16'h0100;
        enable = 1'b1;
        rc = 0;
        for (int i = 0; i < 50 && rc < 4; i++) begin
            cycle();
            if (!bus_if.fx3_nRead) rc++;
            if (busy) enable = 1'b0;
        end
        rst_n = 1'b0;
        cycle();
        chk("t4_nRead", bus_if.fx3_nRead, 1);
        chk("t4_nOE", bus_if.fx3_nOE, 1);
        chk("t4_addr", bus_if.fx3_address, 0);
        chk("t4_valid", bus_if.out_valid, 0);
        chk("t4_busy", busy, 0);
        saved = strobe_cnt;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (8) cycle();
        chk("t4_no_strobe", strobe_cnt, saved);
        exp_q.delete();
        next_word = 16'h0100;
        run_burst(0, 0, 0);
        chk("t4_strobes", strobe_cnt, BL);
        chk("t4_last", last_word, 16'h0107);

        // 5: enable dropped mid-burst, with a pause along the way
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
`ifdef FX3_READ_SEQCHECK_EN
        corrupt = 1'b1;
`endif
        next_word = 16'h0100;
        run_burst(5, 4, 2);
        chk("t5_nrd", nrd_cnt, BL);
        chk("t5_runs", nrd_runs, 2);
        chk("t5_strobes", strobe_cnt, BL);
        chk("t5_sb_empty", exp_q.size(), 0);
        saved = nrd_cnt;
        repeat (20) cycle();
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_nrd", nrd_cnt, saved);
`ifdef FX3_READ_SEQCHECK_EN
        chk("t5_seq_sticky", seq_err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fx3_read_engine.md
Name: fx3_read_engine

Overview:
GPIF-II slave-FIFO reader: FPGA pulls 16-bit words host->FPGA from FX3 thread 1, the reverse direction of the existing sample-write path. It sits beside fx3StateMachine on the same fx3_clock and pin group, with the bus in read direction. It issues fixed-length read bursts and absorbs the FX3 read-data latency. It delivers words to a downstream sink through a valid strobe with almost-full backpressure.

Parameters:
BURST_LEN, 256, words per burst (one FX3 DMA buffer); legal 1..65535
READ_LATENCY, 2, fx3_clock cycles from nRead low to valid data on bus; legal 1..4
TURNAROUND, 2, idle cycles with nOE high after a burst before the next may start

Ports:
fx3_clock  in  1  single clock, 50 MHz FX3 PCLK domain
fx3_nReset  in  1  reset, synchronous, active low
enable  in  1  1 = bursts permitted
fx3_th1Ready  in  1  thread 1 data-available flag; 0 = ready, 1 = not ready
fx3_databus_in  in  16  data bus from FX3
fx3_nRead  out  1  read strobe, active low
fx3_nOE  out  1  FX3 output enable, active low
fx3_address  out  1  thread select; 1 = thread 1 during read
sink_almostFull  in  1  downstream can take at most READ_LATENCY more words
out_data  out  16  received word
out_valid  out  1  out_data valid this cycle (single-cycle strobe per word)
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (fx3_nReset=0 on a rising edge): fx3_nRead=1, fx3_nOE=1, fx3_address=0, out_valid=0, out_data=0, busy=0, issue counter=0, latency pipe cleared, state=IDLE. Reset mid-burst aborts immediately; in-flight words are discarded.
- States: IDLE, SETUP, READ, DRAIN, PAUSE, TURN.
- IDLE: enable=1 && fx3_th1Ready=0 && sink_almostFull=0 -> SETUP. fx3_th1Ready is sampled only in IDLE.
- SETUP (1 cycle): fx3_address=1, fx3_nOE=0. Then -> READ.
- READ: fx3_nRead=0; one read issued per cycle; issue counter +1 per issued read.
  - Issue counter reaches BURST_LEN: deassert nRead on the next cycle, then -> DRAIN.
  - sink_almostFull=1 sampled: deassert nRead on the next cycle, then -> DRAIN (pause path).
  - If both occur in the same cycle, the burst-end path takes priority.
- DRAIN: nRead=1, nOE=0; hold READ_LATENCY cycles for in-flight words.
  - Issue counter == BURST_LEN -> TURN.
  - Otherwise -> PAUSE.
- PAUSE: nRead=1, nOE=0, address=1. sink_almostFull=0 -> READ, resuming the remaining count. fx3_th1Ready is not rechecked.
- TURN: nOE=1, address=0 for TURNAROUND cycles; clear issue counter; -> IDLE.
- Data pipe: shift register of depth READ_LATENCY, fed by ~fx3_nRead.
  - out_valid = pipe tail.
  - When the tail is 1, out_data <= fx3_databus_in, registered in the same cycle out_valid is registered.
  - The first out_valid occurs READ_LATENCY+1 cycles after the first nRead-low edge.
  - Exactly BURST_LEN strobes per burst; the pipe runs independently of state.
- enable=0 mid-burst: the burst completes in full, including pauses. No new burst starts until enable=1.
- Word count per burst is exact; no word is dropped or duplicated across pause/resume.
- out_data holds its last value when out_valid=0.

Optional Feature:
FX3_READ_SEQCHECK_EN
- Defined: adds output seqError (1 bit, sticky) and 16-bit register expected.
  - First valid word after reset loads expected = word+1.
  - Each later valid word is compared to expected. On mismatch seqError<=1 and expected resyncs to word+1; otherwise expected increments and wraps 0xFFFF->0x0000.
  - Cleared only by reset.
  - Used with the host test-pattern mode.
- Undefined: no seqError port or checker logic; behaviour otherwise identical.

Test Plan:
1. BURST_LEN=8, LAT=2, th1Ready=0, bus model returns 0x0100+n -> nRead low exactly 8 consecutive cycles; 8 out_valid strobes carrying 0x0100..0x0107; first strobe 3 cycles after the nRead falling edge; then nOE high 2 cycles; busy falls.
2. Assert sink_almostFull on the 3rd read cycle for 5 cycles -> at most 3+1 issued before the stall; LAT in-flight words still delivered; resume with no gap/duplicate; total 8 words, values contiguous.
3. th1Ready=1 with enable=1 -> stays IDLE, nRead=1, nOE=1, busy=0 indefinitely; drop th1Ready to 0 -> SETUP next cycle.
4. fx3_nReset low on the 4th read cycle -> next edge: nRead=1, nOE=1, address=0, out_valid=0, busy=0; no further strobes; a clean 8-word burst follows after release.
5. enable dropped mid-burst -> burst finishes with 8 strobes, then IDLE with no new burst. With FX3_READ_SEQCHECK_EN, inject 0x0105 where 0x0104 is expected -> seqError=1 held; subsequent words 0x0106.. raise no new error.
